conv2d_stream: RTL and testbench

- Parametrised streaming KxK 2-D convolution engine for raster-order pixel streams, NxM images. Successor to the fixed 3x3, 28x28 engine.
- Adds a runtime-loadable signed kernel and an input-valid stall.
- Row/column counters generate exact output-valid and end-of-frame.
- Sits between the pixel source (PCI DMA FIFO) and the downstream pooling/classifier stage.

---
 rtl/conv_pkg.sv | 32 +++
 rtl/conv_line_buffer.sv | 29 ++
 rtl/conv2d_stream.sv | 183 ++++++++++++++++++
 tb/tb_conv2d_stream.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared helpers and types for the conv2d_stream engine.
// Holds the log2 helper, the accumulator-width derivation and the
// coefficient types for the default 3x3 / 8-bit kernel geometry.
package conv_pkg;

    // Ceiling log2 with a floor of 1 so that every derived port has a width.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >>> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Accumulator width: full signed product plus growth for K*K terms.
    function automatic int conv_aw(input int dw, input int cw, input int k);
        return dw + cw + clog2(k * k) + 1;
    endfunction

    localparam int K_DEF  = 3;
    localparam int CW_DEF = 8;

    // Kernel index r*K+c, signed coefficient and the full KxK kernel.
    typedef logic [clog2(K_DEF*K_DEF)-1:0] coef_idx_t;
    typedef logic signed [CW_DEF-1:0]      coef_t;
    typedef coef_t                         coef_arr_t [K_DEF*K_DEF];

endpackage

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: N-deep, DW-wide shift register that advances only when
// en_i is high. dout_o is the pixel written exactly N accepted beats ago,
// i.e. the same column of the previous image row.
module conv_line_buffer #(
    parameter int N  = 28,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en_i,
    input  logic [DW-1:0] din_i,
    output logic [DW-1:0] dout_o
);

    logic [DW-1:0] sr_q [N];

    // Shift one position per accepted pixel; hold otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) sr_q[i] <= '0;
        end else if (en_i) begin
            sr_q[0] <= din_i;
            for (int i = 1; i < N; i++) sr_q[i] <= sr_q[i-1];
        end
    end

    assign dout_o = sr_q[N-1];

endmodule

// File: rtl/conv2d_stream.sv
// conv2d_stream: streaming KxK 2-D convolution over raster-order NxM frames.
// Build option: define CONV2D_RELU_SAT_EN to clamp results to [0, 2^DW-1].
//
// Stream protocol: valid-only, no backpressure. A pixel is consumed on every
// rising clk edge where in_valid=1 (reset has priority and drops it). Each
// out_valid cycle carries one result on pxl_out; frame_done marks the result
// of the bottom-right window. Results appear 2 clk cycles after the edge that
// accepted the completing pixel.
module conv2d_stream
    import conv_pkg::*;
#(
    parameter int N  = 28,
    parameter int M  = 28,
    parameter int K  = 3,
    parameter int DW = 16,
    parameter int CW = 8,
    parameter int AW = conv_aw(DW, CW, K)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [DW-1:0]            pxl_in,
    input  logic                     coef_we,
    input  logic [clog2(K*K)-1:0]    coef_addr,
    input  logic signed [CW-1:0]     coef_data,
    output logic                     out_valid,
    output logic signed [AW-1:0]     pxl_out,
    output logic                     frame_done,
    output logic [clog2(N)-1:0]      col_cnt,
    output logic [clog2(M)-1:0]      row_cnt
);

    localparam int KK  = K * K;
    localparam int NW  = clog2(N);
    localparam int MW  = clog2(M);
    localparam int PW  = DW + CW + 1;
    localparam int NLB = (K > 1) ? K - 1 : 1;

    // Position counters of the next expected pixel.
    logic [NW-1:0] col_q, col_d;
    logic [MW-1:0] row_q, row_d;
    logic          col_wrap, row_wrap, win_ok;

    // Window, line-buffer taps and the valid/last pipeline.
    logic [DW-1:0]        win_q  [K][K];
    logic [DW-1:0]        col_in [K];
    logic [DW-1:0]        lb_in  [NLB];
    logic [DW-1:0]        lb_out [NLB];
    logic                 v0_q, l0_q, v1_q, l1_q;
    logic signed [CW-1:0] coef_q [KK];
    logic signed [PW-1:0] prod_d [KK];
    logic signed [PW-1:0] prod_q [KK];
    logic signed [AW-1:0] sum_d, res_d;
    logic                 out_valid_q, frame_done_q;
    logic signed [AW-1:0] pxl_out_q;

    // Next counter values and window-valid decode for the current position.
    always_comb begin
        col_wrap = (col_q == NW'(N - 1));
        row_wrap = (row_q == MW'(M - 1));
        col_d    = col_wrap ? '0 : col_q + NW'(1);
        row_d    = row_q;
        if (col_wrap) row_d = row_wrap ? '0 : row_q + MW'(1);
        win_ok   = (int'(row_q) >= K - 1) && (int'(col_q) >= K - 1);
    end

    // K-1 chained line buffers; buffer i yields the pixel i+1 rows above.
    generate
        if (K > 1) begin : g_lb
            for (genvar i = 0; i < K - 1; i++) begin : g_buf
                if (i == 0) begin : g_head
                    assign lb_in[i] = pxl_in;
                end else begin : g_chain
                    assign lb_in[i] = lb_out[i-1];
                end
                conv_line_buffer #(.N(N), .DW(DW)) u_lb (
                    .clk    (clk),
                    .reset  (reset),
                    .en_i   (in_valid),
                    .din_i  (lb_in[i]),
                    .dout_o (lb_out[i])
                );
            end
        end else begin : g_no_lb
            assign lb_in[0]  = '0;
            assign lb_out[0] = '0;
        end
    endgenerate

    // New right-hand window column: oldest row on top, live pixel at bottom.
    always_comb begin
        for (int r = 0; r < K - 1; r++) col_in[r] = lb_out[K-2-r];
        col_in[K-1] = pxl_in;
    end

    // Counters and window shift on each accepted pixel; valid pulse per window.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_q <= '0;
            row_q <= '0;
            v0_q  <= 1'b0;
            l0_q  <= 1'b0;
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++) win_q[r][c] <= '0;
        end else begin
            v0_q <= in_valid && win_ok;
            l0_q <= in_valid && win_ok && col_wrap && row_wrap;
            if (in_valid) begin
                col_q <= col_d;
                row_q <= row_d;
                for (int r = 0; r < K; r++) begin
                    for (int c = 0; c < K - 1; c++) win_q[r][c] <= win_q[r][c+1];
                    win_q[r][K-1] <= col_in[r];
                end
            end
        end
    end

    // Coefficient RAM; addresses outside the kernel are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < KK; i++) coef_q[i] <= '0;
        end else if (coef_we && (int'(coef_addr) < KK)) begin
            coef_q[coef_addr] <= coef_data;
        end
    end

    // Products: pixel zero-extended to signed, both operands widened first.
    always_comb begin
        for (int i = 0; i < KK; i++)
            prod_d[i] = PW'($signed({1'b0, win_q[i/K][i%K]})) * PW'(coef_q[i]);
    end

    // Stage 1: register products; the pipeline runs every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < KK; i++) prod_q[i] <= '0;
            v1_q <= 1'b0;
            l1_q <= 1'b0;
        end else begin
            for (int i = 0; i < KK; i++) prod_q[i] <= prod_d[i];
            v1_q <= v0_q;
            l1_q <= l0_q;
        end
    end

`ifdef CONV2D_RELU_SAT_EN
    localparam logic [AW-1:0] PIX_MAX = {{(AW-DW){1'b0}}, {DW{1'b1}}};
`endif

    // Adder tree and optional ReLU/saturation of the final sum.
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < KK; i++) sum_d = sum_d + AW'(prod_q[i]);
        res_d = sum_d;
`ifdef CONV2D_RELU_SAT_EN
        if (sum_d[AW-1])
            res_d = '0;
        else if ($unsigned(sum_d) > PIX_MAX)
            res_d = $signed(PIX_MAX);
`endif
    end

    // Stage 2: registered outputs; pxl_out holds between valid results.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            pxl_out_q    <= '0;
        end else begin
            out_valid_q  <= v1_q;
            frame_done_q <= l1_q;
            if (v1_q) pxl_out_q <= res_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;
    assign pxl_out    = pxl_out_q;
    assign col_cnt    = col_q;
    assign row_cnt    = row_q;

endmodule

// File: tb/tb_conv2d_stream.sv
// tb_conv2d_stream: randomized self-checking bench for conv2d_stream using a
// frame-array reference model (8x6 image, 3x3 kernel).
module tb_conv2d_stream;
  import conv_pkg::*;

  localparam int N   = 8;
  localparam int M   = 6;
  localparam int K   = 3;
  localparam int DW  = 16;
  localparam int CW  = 8;
  localparam int KK  = K * K;
  localparam int AW  = DW + CW + 4 + 1;
  localparam int WPF = (M - K + 1) * (N - K + 1);

  // ---------------- clock / reset / DUT ----------------
  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 in_valid = 1'b0;
  logic [DW-1:0]        pxl_in = '0;
  logic                 coef_we = 1'b0;
  coef_idx_t            coef_addr = '0;
  coef_t                coef_data = '0;
  logic                 out_valid;
  logic signed [AW-1:0] pxl_out;
  logic                 frame_done;
  logic [2:0]           col_cnt;
  logic [2:0]           row_cnt;

  always #5 clk = ~clk;

  conv2d_stream #(.N(N), .M(M), .K(K), .DW(DW), .CW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .pxl_in     (pxl_in),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .out_valid  (out_valid),
    .pxl_out    (pxl_out),
    .frame_done (frame_done),
    .col_cnt    (col_cnt),
    .row_cnt    (row_cnt)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic signed [63:0] obs,
                          input logic signed [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Stores the current frame as a plain array and evaluates each complete
  // window directly with the kernel in force after the accepting edge.
  int          m_col = 0;
  int          m_row = 0;
  longint      kern [KK];
  longint      hist [M*N];
  logic [AW:0] exp_q [$];
  int          due_q [$];
  int          cyc = 0;
  int          reset_gen = 0;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_col = 0;
      m_row = 0;
      for (int i = 0; i < KK; i++) kern[i] = 0;
      exp_q.delete();
      due_q.delete();
      reset_gen++;
    end else begin
      if (coef_we && int'(coef_addr) < KK) kern[coef_addr] = longint'(coef_data);
      if (in_valid) begin
        hist[m_row*N + m_col] = longint'(pxl_in);
        if (m_row >= K - 1 && m_col >= K - 1) begin
          longint s;
          logic   last;
          s = 0;
          for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
              s += kern[r*K + c] * hist[(m_row - K + 1 + r)*N + (m_col - K + 1 + c)];
`ifdef CONV2D_RELU_SAT_EN
          if (s < 0) s = 0;
          else if (s > (longint'(1) << DW) - 1) s = (longint'(1) << DW) - 1;
`endif
          last = (m_row == M - 1) && (m_col == N - 1);
          exp_q.push_back({last, AW'(s)});
          due_q.push_back(cyc + 2);
        end
        m_col++;
        if (m_col == N) begin
          m_col = 0;
          m_row++;
          if (m_row == M) m_row = 0;
        end
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  bit                 mon_en = 1'b0;
  int                 seen_gen = 0;
  logic signed [63:0] last_out = 0;
  logic signed [63:0] obs_last = 0;
  int                 out_cnt = 0;
  int                 done_cnt = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      logic [AW:0] e;
      if (seen_gen != reset_gen) begin
        seen_gen = reset_gen;
        last_out = 0;
      end
      check_eq("col_cnt", col_cnt, m_col);
      check_eq("row_cnt", row_cnt, m_row);
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        e = exp_q.pop_front();
        due_q.delete(0);
        check_eq("out_valid", out_valid, 1);
        check_eq("pxl_out", pxl_out, $signed(e[AW-1:0]));
        check_eq("frame_done", frame_done, e[AW]);
        last_out = $signed(e[AW-1:0]);
      end else begin
        check_eq("out_valid_idle", out_valid, 0);
        check_eq("frame_done_idle", frame_done, 0);
        check_eq("pxl_out_hold", pxl_out, last_out);
      end
      if (out_valid) begin
        out_cnt++;
        obs_last = pxl_out;
      end
      if (frame_done) done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  logic [DW-1:0] img [M*N];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_coef(input int addr, input int data);
    coef_we   = 1'b1;
    coef_addr = coef_idx_t'(addr);
    coef_data = coef_t'(data);
    tick();
    coef_we   = 1'b0;
  endtask

  // kind 0: identity, 1: all ones, 2: top-left -128, 3: random
  task automatic set_kernel(input int kind);
    for (int i = 0; i < KK; i++) begin
      case (kind)
        0:       write_coef(i, (i == KK / 2) ? 1 : 0);
        1:       write_coef(i, 1);
        2:       write_coef(i, (i == 0) ? -128 : 0);
        default: write_coef(i, int'($urandom_range(0, 255)) - 128);
      endcase
    end
  endtask

  // mode 0: pixel = row*N+col, 1: constant val, 2: img[]
  // stall 0: none, 1: idle every other cycle, 2: random idles + random coef writes
  // abort_at >= 0: assert reset together with that pixel and stop
  task automatic drive_frame(input int mode, input int val, input int stall, input int abort_at);
    for (int p = 0; p < M * N; p++) begin
      if (stall == 1) begin
        in_valid = 1'b0;
        pxl_in   = DW'($urandom);
        tick();
      end else if (stall == 2) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          pxl_in   = DW'($urandom);
          tick();
        end
      end
      in_valid = 1'b1;
      case (mode)
        0:       pxl_in = DW'(p);
        1:       pxl_in = DW'(val);
        default: pxl_in = img[p];
      endcase
      if (stall == 2 && $urandom_range(0, 15) == 0) begin
        coef_we   = 1'b1;
        coef_addr = coef_idx_t'($urandom_range(0, 15));
        coef_data = coef_t'($urandom_range(0, 255));
      end
      if (p == abort_at) reset = 1'b1;
      tick();
      coef_we = 1'b0;
      reset   = 1'b0;
      if (p == abort_at) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    repeat (4) tick();
    check_eq("queue_drained", exp_q.size(), 0);
  endtask

  task automatic check_counts(input string tag, input int o0, input int d0, input int frames);
    check_eq({tag, "_out_count"}, out_cnt - o0, frames * WPF);
    check_eq({tag, "_done_count"}, done_cnt - d0, frames);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int o0, d0;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_pxl_out", pxl_out, 0);
    check_eq("rst_frame_done", frame_done, 0);
    check_eq("rst_col_cnt", col_cnt, 0);
    check_eq("rst_row_cnt", row_cnt, 0);
    mon_en = 1'b1;

    // Identity kernel on a ramp image: outputs are the window centres.
    set_kernel(0);
    o0 = out_cnt; d0 = done_cnt;
    drive_frame(0, 0, 0, -1);
    drain();
    check_counts("identity", o0, d0, 1);
    check_eq("identity_last", obs_last, (M - 2) * N + (N - 2));

    // All-ones kernel on constant 2, continuous then with alternating stalls.
    set_kernel(1);
    o0 = out_cnt; d0 = done_cnt;
    drive_frame(1, 2, 0, -1);
    drain();
    check_counts("ones", o0, d0, 1);
    check_eq("ones_const2", obs_last, 18);
    o0 = out_cnt; d0 = done_cnt;
    drive_frame(1, 2, 1, -1);
    drain();
    check_counts("ones_stall", o0, d0, 1);
    check_eq("ones_stall_const2", obs_last, 18);

    // Extreme values: large negative and large positive sums.
    set_kernel(2);
    drive_frame(1, 65535, 0, -1);
    drain();
`ifdef CONV2D_RELU_SAT_EN
    check_eq("corner_neg", obs_last, 0);
`else
    check_eq("corner_neg", obs_last, -8388480);
`endif
    set_kernel(1);
    drive_frame(1, 65535, 0, -1);
    drain();
`ifdef CONV2D_RELU_SAT_EN
    check_eq("ones_max", obs_last, 65535);
`else
    check_eq("ones_max", obs_last, 589815);
`endif

    // Random kernels and images, random stalls and mid-frame coef writes.
    for (int f = 0; f < 4; f++) begin
      set_kernel(3);
      for (int i = 0; i < M * N; i++) img[i] = DW'($urandom);
      o0 = out_cnt; d0 = done_cnt;
      drive_frame(2, 0, 2, -1);
      drain();
      check_counts("random", o0, d0, 1);
    end

    // Reset together with pixel 20 while windows are in flight.
    set_kernel(3);
    for (int i = 0; i < M * N; i++) img[i] = DW'($urandom);
    o0 = out_cnt; d0 = done_cnt;
    drive_frame(2, 0, 0, 20);
    @(negedge clk);
    check_eq("post_rst_valid_0", out_valid, 0);
    check_eq("post_rst_col", col_cnt, 0);
    @(negedge clk);
    check_eq("post_rst_valid_1", out_valid, 0);
    check_eq("post_rst_row", row_cnt, 0);
    check_counts("aborted", o0, d0, 0);
    set_kernel(3);
    o0 = out_cnt; d0 = done_cnt;
    drive_frame(2, 0, 2, -1);
    drain();
    check_counts("after_reset", o0, d0, 1);

    // Back-to-back frames, out-of-range coef write, then the same frame again.
    set_kernel(3);
    for (int i = 0; i < M * N; i++) img[i] = DW'($urandom);
    o0 = out_cnt; d0 = done_cnt;
    drive_frame(2, 0, 0, -1);
    drive_frame(2, 0, 0, -1);
    write_coef(9, 77);
    write_coef(15, -5);
    drive_frame(2, 0, 0, -1);
    drain();
    check_counts("b2b", o0, d0, 3);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #2000000;
    n_fail++;
    $display("FAIL timeout: observed no finish expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
